// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED mode sequencer.
// Holds the mode encodings, the state-bus width seen by the LED mux, the
// double-flash frame and a helper that computes the "next" mode.
package led_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [1:0] {
    MODE_OFF          = 2'b00,
    MODE_ON           = 2'b01,
    MODE_BLINK_SLOW   = 2'b10,
    MODE_DOUBLE_FLASH = 2'b11
  } led_mode_e;

  // Bit i is the pattern2 level while the frame index equals i.
  localparam logic [7:0] DOUBLE_FLASH_FRAME = 8'b00000101;

  // OFF -> ON -> BLINK_SLOW -> DOUBLE_FLASH -> OFF
  function automatic led_mode_e next_mode(input led_mode_e m);
    return led_mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Tick prescaler for the LED mode sequencer.
// Counts 0..PRESCALE-1 and raises tick for the single cycle in which the
// count sits at PRESCALE-1; the count then wraps to 0.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   clr  - restart the count at 0 on the next edge
//   tick - one-cycle pulse every PRESCALE cycles
module led_tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// LED mode sequencer.
// Holds the current LED mode, accepts changes from a "next" pulse or a
// direct command, refuses further requests during a tick-based lockout and
// generates the slow-blink (pattern1) and double-flash (pattern2) waveforms.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   next_pulse - advance to the next mode
//   cmd_valid  - direct command valid, cmd_mode = requested mode
//   cmd_ready  - high when a request would be accepted this cycle
//   state      - {1'b0, mode} to the LED mux
//   pattern1   - slow square wave, 2*SLOW_HALF ticks period
//   pattern2   - double flash, 8-tick frame
// Optional: define LED_MODE_SEQ_AUTO_OFF_EN to force OFF after
// AUTO_OFF_TICKS idle ticks.
//
// state             | meaning
// ------------------+-----------------------------------------
// MODE_OFF          | LED dark
// MODE_ON           | LED steady on
// MODE_BLINK_SLOW   | mux selects pattern1
// MODE_DOUBLE_FLASH | mux selects pattern2
module led_mode_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int PRESCALE       = 1000,
  parameter int SLOW_HALF      = 4,
  parameter int LOCKOUT        = 8,
  parameter int AUTO_OFF_TICKS = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               next_pulse,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_mode,
  output logic               cmd_ready,
  output logic [STATE_W-1:0] state,
  output logic               pattern1,
  output logic               pattern2
);

  localparam int LW = $clog2(LOCKOUT + 1);
  localparam int SW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;

  if (PRESCALE < 2 || SLOW_HALF < 1 || LOCKOUT < 1 ||
      AUTO_OFF_TICKS < 1 || AUTO_OFF_TICKS > 65535) begin : g_bad_param
    $error("led_mode_sequencer: parameter out of range");
  end

  led_mode_e     mode_q, mode_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [SW-1:0] slow_cnt_q, slow_cnt_d;
  logic          p1_q, p1_d;
  logic [2:0]    idx_q, idx_d;
  logic          p2_q, p2_d;

  logic      tick;
  logic      accept;
  logic      auto_off;
  logic      restart;
  led_mode_e target;

  led_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart),
    .tick (tick)
  );

  assign cmd_ready = (lock_q == '0);
  assign state     = {1'b0, mode_q};
  assign pattern1  = p1_q;
  assign pattern2  = p2_q;

  // Mode FSM: a command beats next_pulse; auto-off only applies when no
  // request is accepted in the same cycle.
  always_comb begin
    accept  = cmd_ready && (cmd_valid || next_pulse);
    target  = cmd_valid ? led_mode_e'(cmd_mode) : next_mode(mode_q);
    restart = accept || auto_off;
    mode_d  = mode_q;
    if (accept)        mode_d = target;
    else if (auto_off) mode_d = MODE_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) mode_q <= MODE_OFF;
    else     mode_q <= mode_d;
  end

  // Lockout and pattern generators. A restart dominates any tick landing in
  // the same cycle, so every waveform starts its first level afresh.
  always_comb begin
    lock_d     = lock_q;
    slow_cnt_d = slow_cnt_q;
    p1_d       = p1_q;
    idx_d      = idx_q;
    p2_d       = p2_q;
    if (restart) begin
      lock_d     = LW'(LOCKOUT);
      slow_cnt_d = '0;
      p1_d       = 1'b1;
      idx_d      = 3'd0;
      p2_d       = DOUBLE_FLASH_FRAME[0];
    end else if (tick) begin
      if (lock_q != '0) lock_d = lock_q - 1'b1;
      if (slow_cnt_q == SW'(SLOW_HALF - 1)) begin
        slow_cnt_d = '0;
        p1_d       = ~p1_q;
      end else begin
        slow_cnt_d = slow_cnt_q + 1'b1;
      end
      idx_d = idx_q + 3'd1;
      p2_d  = DOUBLE_FLASH_FRAME[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= '0;
      slow_cnt_q <= '0;
      p1_q       <= 1'b0;
      idx_q      <= 3'd0;
      p2_q       <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      slow_cnt_q <= slow_cnt_d;
      p1_q       <= p1_d;
      idx_q      <= idx_d;
      p2_q       <= p2_d;
    end
  end

`ifdef LED_MODE_SEQ_AUTO_OFF_EN
  localparam logic [15:0] AUTO_OFF_MAX  = 16'(AUTO_OFF_TICKS);
  localparam logic [15:0] AUTO_OFF_LAST = 16'(AUTO_OFF_TICKS - 1);

  logic [15:0] idle_q, idle_d;

  // Fires on the tick that brings the idle count to AUTO_OFF_TICKS; in OFF
  // the count simply saturates there until the next accepted request.
  always_comb begin
    auto_off = 1'b0;
    idle_d   = idle_q;
    if (accept) begin
      idle_d = '0;
    end else if (tick && idle_q != AUTO_OFF_MAX) begin
      if (idle_q == AUTO_OFF_LAST && mode_q != MODE_OFF) begin
        auto_off = 1'b1;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign auto_off = 1'b0;
`endif

endmodule

// File: tb/tb_led_mode_sequencer.sv
module tb_led_mode_sequencer;

  localparam int P  = 4;
  localparam int SH = 2;
  localparam int L  = 3;
  localparam int LP = L * P;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       next_pulse = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'b00;
  logic       cmd_ready;
  logic [2:0] state;
  logic       pattern1;
  logic       pattern2;

  always #5 clk = ~clk;

  led_mode_sequencer #(
    .PRESCALE(P), .SLOW_HALF(SH), .LOCKOUT(L), .AUTO_OFF_TICKS(65535)
  ) dut (
    .clk(clk), .rst(rst), .next_pulse(next_pulse), .cmd_valid(cmd_valid),
    .cmd_mode(cmd_mode), .cmd_ready(cmd_ready), .state(state),
    .pattern1(pattern1), .pattern2(pattern2)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       p1;
    logic       p2;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: everything is derived from the number of clock edges
  // since the last mode change (or reset).
  int unsigned e_cnt  = 0;
  int unsigned base   = 0;
  bit          has_ev = 0;
  int          m_mode = 0;
  int          frame[8] = '{1, 0, 1, 0, 0, 0, 0, 0};

  function automatic bit m_ready();
    if (!has_ev) return 1'b1;
    return (e_cnt - base) >= LP;
  endfunction

  function automatic exp_t m_expect();
    exp_t x;
    int unsigned since = e_cnt - base;
    int unsigned ticks = since / P;
    x.st = 3'(m_mode);
    if (has_ev) begin
      x.p1  = ((ticks / SH) % 2) == 0;
      x.p2  = frame[ticks % 8] == 1;
      x.rdy = since >= LP;
    end else begin
      x.p1  = ((ticks / SH) % 2) == 1;
      x.p2  = (ticks != 0) && (frame[ticks % 8] == 1);
      x.rdy = 1'b1;
    end
    return x;
  endfunction

  task automatic step(input logic r, input logic cv, input logic nv,
                      input logic [1:0] cm);
    bit rdy_before;
    rst = r; cmd_valid = cv; next_pulse = nv; cmd_mode = cm;
    rdy_before = m_ready();
    @(posedge clk);
    e_cnt++;
    if (r) begin
      has_ev = 0; base = e_cnt; m_mode = 0;
    end else if (rdy_before && (cv || nv)) begin
      m_mode = cv ? int'(cm) : (m_mode + 1) % 4;
      has_ev = 1; base = e_cnt;
    end
    #1;
    sb_q.push_back(m_expect());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!m_ready() && guard < 1000) begin
      step(1'b0, 1'b0, 1'b0, 2'b00);
      guard++;
    end
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("state",     int'(state),     int'(x.st));
        check("pattern1",  int'(pattern1),  int'(x.p1));
        check("pattern2",  int'(pattern2),  int'(x.p2));
        check("cmd_ready", int'(cmd_ready), int'(x.rdy));
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    idle(40);

    for (int k = 0; k < 4; k++) begin
      wait_ready();
      step(1'b0, 1'b0, 1'b1, 2'b00);
      idle(1);
    end

    wait_ready();
    step(1'b0, 1'b1, 1'b0, 2'b10);
    idle(70);

    wait_ready();
    step(1'b0, 1'b1, 1'b0, 2'b00);
    wait_ready();
    step(1'b0, 1'b1, 1'b1, 2'b01);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 2'b00);
    idle(3);

    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 2'b11);
    idle(5);

    step(1'b0, 1'b1, 1'b0, 2'b01);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    idle(10);

    for (int i = 0; i < 4000; i++) begin
      logic r, cv, nv;
      logic [1:0] cm;
      r  = ($urandom_range(0, 499) == 0);
      cv = ($urandom_range(0, 5) == 0);
      nv = ($urandom_range(0, 3) == 0);
      cm = 2'($urandom_range(0, 3));
      step(r, cv, nv, cm);
    end

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
